// File: rtl/glitc_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : glitc_align_ctrl
// Description : Per-channel training controller for the GLITC input path
//               (IDELAY + ISERDES 1:4). It sweeps all 32 IDELAY taps and
//               checks the deserialized word against PATTERN at each tap.
//               It then loads the centre of the longest passing window. If
//               no window is wide enough, it issues a bitslip and rescans.
// Ports       : clk_i      control clock
//               rst_i      synchronous active-high reset
//               start_i    one-cycle alignment request (ignored while busy)
//               serdes_i   4-bit deserialized word (already in clk_i domain)
//               delay_o    IDELAY tap value
//               load_o     one-cycle IDELAY load strobe
//               bitslip_o  one-cycle ISERDES bitslip strobe
//               busy_o     alignment in progress
//               done_o     sticky success flag
//               fail_o     sticky failure flag
//               eye_o      pass map of the last scan (bit n = tap n passed)
//               slips_o    bitslips issued in the current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module glitc_align_ctrl #(
    parameter logic [3:0] PATTERN       = 4'b1010,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         NSAMPLES      = 64,
    parameter int         MIN_EYE       = 4,
    parameter int         MAX_SLIPS     = 4,
    parameter int         SLIP_WAIT     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  serdes_i,
    output logic [4:0]  delay_o,
    output logic        load_o,
    output logic        bitslip_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [31:0] eye_o,
    output logic [2:0]  slips_o
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_sample_last = 8'(NSAMPLES - 1);
    localparam logic [7:0] c_slip_last   = 8'(SLIP_WAIT - 1);
    localparam logic [5:0] c_min_eye     = 6'(MIN_EYE);
    localparam logic [2:0] c_max_slips   = 3'(MAX_SLIPS);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD      = 4'd1,
        S_SETTLE    = 4'd2,
        S_SAMPLE    = 4'd3,
        S_NEXT      = 4'd4,
        S_ANALYZE   = 4'd5,
        S_SLIP      = 4'd6,
        S_SLIP_WAIT = 4'd7,
        S_APPLY     = 4'd8,
        S_DONE      = 4'd9,
        S_FAIL      = 4'd10
    } state_t;

    state_t      r_state;
    logic [5:0]  r_tap;         // scan tap, reused as the analysis index
    logic [7:0]  r_cnt;
    logic        r_pass;
    logic [4:0]  r_delay;
    logic        r_load;
    logic        r_bitslip;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic [31:0] r_eye;
    logic [2:0]  r_slips;
    logic [4:0]  r_cur_start;
    logic [5:0]  r_cur_len;
    logic [4:0]  r_best_start;
    logic [5:0]  r_best_len;

    logic        w_match;
    logic        w_bit;
    logic [4:0]  w_cur_start;
    logic [5:0]  w_cur_len;
    logic [4:0]  w_best_start;
    logic [5:0]  w_best_len;

    assign w_match = (serdes_i == PATTERN);

    // Run tracking for the tap under analysis. The "next" best values feed
    // both the registers and the final decision, so tap 31 counts in the
    // verdict in the same cycle it is examined.
    always_comb begin
        w_bit        = r_eye[r_tap[4:0]];
        w_cur_start  = r_cur_start;
        w_cur_len    = 6'd0;
        w_best_start = r_best_start;
        w_best_len   = r_best_len;
        if (w_bit) begin
            w_cur_len = r_cur_len + 6'd1;
            if (r_cur_len == 6'd0) begin
                w_cur_start = r_tap[4:0];
            end
        end
        // Strictly longer only: on a tie the earlier window is kept.
        if (w_cur_len > r_best_len) begin
            w_best_len   = w_cur_len;
            w_best_start = w_cur_start;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_tap        <= 6'd0;
            r_cnt        <= 8'd0;
            r_pass       <= 1'b0;
            r_delay      <= 5'd0;
            r_load       <= 1'b0;
            r_bitslip    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_eye        <= 32'd0;
            r_slips      <= 3'd0;
            r_cur_start  <= 5'd0;
            r_cur_len    <= 6'd0;
            r_best_start <= 5'd0;
            r_best_len   <= 6'd0;
        end else begin
            // Strobes are set on the transition into the state that owns
            // them, so they are high exactly during that state's cycle.
            r_load    <= 1'b0;
            r_bitslip <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_slips <= 3'd0;
                        r_tap   <= 6'd0;
                        r_eye   <= 32'd0;
                        r_delay <= 5'd0;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt   <= 8'd0;
                        r_pass  <= 1'b1;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (!w_match) begin
                        r_pass <= 1'b0;
                    end
                    if (r_cnt == c_sample_last) begin
                        r_eye[r_tap[4:0]] <= r_pass & w_match;
                        r_state           <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (r_tap == 6'd31) begin
                        r_tap        <= 6'd0;
                        r_cur_start  <= 5'd0;
                        r_cur_len    <= 6'd0;
                        r_best_start <= 5'd0;
                        r_best_len   <= 6'd0;
                        r_state      <= S_ANALYZE;
                    end else begin
                        r_tap   <= r_tap + 6'd1;
                        r_delay <= r_tap[4:0] + 5'd1;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_ANALYZE: begin
                    r_cur_start  <= w_cur_start;
                    r_cur_len    <= w_cur_len;
                    r_best_start <= w_best_start;
                    r_best_len   <= w_best_len;
                    if (r_tap == 6'd31) begin
                        r_tap <= 6'd0;
                        if (w_best_len >= c_min_eye) begin
                            // Centre always fits in 5 bits: start + half-len <= 31.
                            r_delay <= 5'({1'b0, w_best_start} + ((w_best_len - 6'd1) >> 1));
                            r_load  <= 1'b1;
                            r_state <= S_APPLY;
                        end else if (r_slips < c_max_slips) begin
                            r_bitslip <= 1'b1;
                            r_slips   <= r_slips + 3'd1;
                            r_eye     <= 32'd0;
                            r_state   <= S_SLIP;
                        end else begin
                            r_delay <= 5'd0;
                            r_load  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_fail  <= 1'b1;
                            r_state <= S_FAIL;
                        end
                    end else begin
                        r_tap <= r_tap + 6'd1;
                    end
                end
                S_SLIP: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_SLIP_WAIT;
                end
                S_SLIP_WAIT: begin
                    if (r_cnt == c_slip_last) begin
                        r_delay <= 5'd0;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_APPLY: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign delay_o   = r_delay;
    assign load_o    = r_load;
    assign bitslip_o = r_bitslip;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign fail_o    = r_fail;
    assign eye_o     = r_eye;
    assign slips_o   = r_slips;

endmodule
`default_nettype wire

// File: tb/tb_glitc_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitc_align_ctrl
// Description : Self-checking bench for glitc_align_ctrl. An IDELAY/ISERDES
//               stand-in returns PATTERN or its inverse depending on the
//               loaded tap and the number of bitslips seen. Directed vectors
//               and random eye maps are compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitc_align_ctrl;

    localparam logic [3:0] c_pattern = 4'b1010;
    localparam int c_settle    = 3;
    localparam int c_nsamples  = 5;
    localparam int c_min_eye   = 4;
    localparam int c_max_slips = 4;
    localparam int c_slip_wait = 4;
    localparam int c_inj_k     = c_settle + 1 + c_nsamples / 2;
    localparam int c_limit     = 20000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  serdes_i;
    logic [4:0]  delay_o;
    logic        load_o;
    logic        bitslip_o;
    logic        busy_o;
    logic        done_o;
    logic        fail_o;
    logic [31:0] eye_o;
    logic [2:0]  slips_o;

    glitc_align_ctrl #(
        .PATTERN      (c_pattern),
        .SETTLE_CYCLES(c_settle),
        .NSAMPLES     (c_nsamples),
        .MIN_EYE      (c_min_eye),
        .MAX_SLIPS    (c_max_slips),
        .SLIP_WAIT    (c_slip_wait)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .serdes_i (serdes_i),
        .delay_o  (delay_o),
        .load_o   (load_o),
        .bitslip_o(bitslip_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .fail_o   (fail_o),
        .eye_o    (eye_o),
        .slips_o  (slips_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Channel stand-in state
    logic [31:0] g_m0 = 32'd0;     // pass map before any bitslip
    logic [31:0] g_m1 = 32'd0;     // pass map after one or more bitslips
    int          g_inj = -1;       // tap that sees one injected mismatch
    int          bs_base = 0;
    int          applied = 0;
    int          since_load = 0;
    int          load_pulses = 0;
    int          bs_pulses = 0;
    int          overlap = 0;

    initial serdes_i = ~c_pattern;

    always @(posedge clk_i) begin
        logic [31:0] msk;
        #1;
        if (load_o) begin
            applied    = int'(delay_o);
            since_load = 0;
            load_pulses++;
        end else begin
            since_load++;
        end
        if (bitslip_o) bs_pulses++;
        if (load_o && bitslip_o) overlap++;
        msk = (bs_pulses == bs_base) ? g_m0 : g_m1;
        if (msk[applied] && !(applied == g_inj && since_load == c_inj_k))
            serdes_i = c_pattern;
        else
            serdes_i = ~c_pattern;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: scan-by-scan verdict from the pass maps, with cycle cost.
    function automatic void model(input logic [31:0] m0, input logic [31:0] m1, input int inj,
                                  output logic [31:0] eye, output logic [4:0] dly,
                                  output int sl, output bit ok, output int busy);
        int bl, bs, len;
        logic [31:0] m;
        bit fin;
        fin = 0; ok = 0; dly = 5'd0; eye = 32'd0; sl = 0; busy = 0;
        for (int s = 0; s <= c_max_slips; s++) begin
            if (!fin) begin
                m = (s == 0) ? m0 : m1;
                if (inj >= 0) m[inj] = 1'b0;
                bl = 0; bs = 0;
                for (int i = 0; i < 32; i++) begin
                    len = 0;
                    while (i + len < 32 && m[i + len]) len++;
                    if (len > bl) begin bl = len; bs = i; end
                end
                eye  = m;
                sl   = s;
                busy += 32 * (c_settle + c_nsamples + 2) + 32;
                if (bl >= c_min_eye) begin
                    ok = 1; dly = 5'(bs + (bl - 1) / 2); busy += 1; fin = 1;
                end else if (s == c_max_slips) begin
                    fin = 1;
                end else begin
                    busy += 1 + c_slip_wait;
                end
            end
        end
    endfunction

    int busy_cnt;
    int bs_cnt;

    task automatic run(input string tag, input logic [31:0] m0, input logic [31:0] m1, input int inj);
        g_m0 = m0; g_m1 = m1; g_inj = inj; bs_base = bs_pulses;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        check({tag, ".start"}, {59'd0, busy_o, done_o, fail_o, (eye_o != 0), (slips_o != 0)}, 64'b10000);
        busy_cnt = 1;
        while (busy_cnt <= c_limit) begin
            @(negedge clk_i);
            start_i = (busy_cnt == 20);   // must be ignored while busy
            if (busy_o) busy_cnt++;
            else break;
        end
        start_i = 1'b0;
        if (busy_cnt > c_limit) check({tag, ".timeout"}, 64'(busy_cnt), 64'(c_limit));
        bs_cnt = bs_pulses - bs_base;
    endtask

    task automatic verify(input string tag, input logic [31:0] e_eye, input logic [4:0] e_dly,
                          input int e_sl, input bit e_ok, input int e_busy);
        check({tag, ".eye"},     64'(eye_o),     64'(e_eye));
        check({tag, ".delay"},   64'(delay_o),   64'(e_dly));
        check({tag, ".slips"},   64'(slips_o),   64'(e_sl));
        check({tag, ".done"},    64'(done_o),    64'(e_ok));
        check({tag, ".fail"},    64'(fail_o),    64'(!e_ok));
        check({tag, ".busy"},    64'(busy_cnt),  64'(e_busy));
        check({tag, ".bitslip"}, 64'(bs_cnt),    64'(e_sl));
        check({tag, ".overlap"}, 64'(overlap),   64'd0);
    endtask

    function automatic logic [31:0] win(input int s, input int l);
        logic [31:0] m;
        m = 32'd0;
        for (int i = s; i < s + l && i < 32; i++) m[i] = 1'b1;
        return m;
    endfunction

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        int          inj;
        logic [31:0] eye;
        logic [4:0]  dly;
        int          sl;
        bit          ok;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] r_eye_e;
        logic [4:0]  r_dly_e;
        int          r_sl_e, r_busy_e, lp, bp, guard;
        bit          r_ok_e;
        logic [31:0] m0, m1;

        tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'hFFFFFFFF, 5'd15, 0, 1'b1};
        tbl[1] = '{32'h001FFF00, 32'h001FFF00, -1, 32'h001FFF00, 5'd14, 0, 1'b1};
        tbl[2] = '{32'h001FFC3C, 32'h001FFC3C, -1, 32'h001FFC3C, 5'd15, 0, 1'b1};
        tbl[3] = '{32'h01F0007C, 32'h01F0007C, -1, 32'h01F0007C, 5'd4,  0, 1'b1};
        tbl[4] = '{32'h00000000, 32'h00000000, -1, 32'h00000000, 5'd0,  4, 1'b0};
        tbl[5] = '{32'h00000000, 32'hFFFFFFFF, -1, 32'hFFFFFFFF, 5'd15, 1, 1'b1};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 15, 32'hFFFF7FFF, 5'd23, 0, 1'b1};
        tbl[7] = '{32'h00000007, 32'h0000000F, -1, 32'h0000000F, 5'd1,  1, 1'b1};
        tbl[8] = '{32'hF0000000, 32'hF0000000, -1, 32'hF0000000, 5'd29, 0, 1'b1};

        rst_i = 1'b1; start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset", 64'({delay_o, load_o, bitslip_o, busy_o, done_o, fail_o, eye_o, slips_o}), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("idle", 64'({delay_o, load_o, bitslip_o, busy_o, done_o, fail_o, eye_o, slips_o}), 64'd0);

        for (int k = 0; k < 9; k++) begin
            run($sformatf("vec%0d", k), tbl[k].m0, tbl[k].m1, tbl[k].inj);
            model(tbl[k].m0, tbl[k].m1, tbl[k].inj, r_eye_e, r_dly_e, r_sl_e, r_ok_e, r_busy_e);
            verify($sformatf("vec%0d", k), tbl[k].eye, tbl[k].dly, tbl[k].sl, tbl[k].ok, r_busy_e);
        end

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 2))
                0:       m0 = win($urandom_range(0, 31), $urandom_range(1, 12));
                1:       m0 = win($urandom_range(0, 15), $urandom_range(1, 8)) |
                              win($urandom_range(16, 31), $urandom_range(1, 8));
                default: m0 = $urandom;
            endcase
            m1 = ($urandom_range(0, 1) == 1) ? win($urandom_range(0, 28), $urandom_range(4, 20)) : $urandom;
            run($sformatf("rnd%0d", k), m0, m1, (k % 2 == 1) ? int'($urandom_range(0, 31)) : -1);
            model(m0, m1, g_inj, r_eye_e, r_dly_e, r_sl_e, r_ok_e, r_busy_e);
            verify($sformatf("rnd%0d", k), r_eye_e, r_dly_e, r_sl_e, r_ok_e, r_busy_e);
        end

        // Reset while sampling tap 7
        g_m0 = 32'hFFFFFFFF; g_m1 = 32'hFFFFFFFF; g_inj = -1; bs_base = bs_pulses;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        guard = 0;
        while (!(applied == 7 && since_load == c_settle + 2) && guard < c_limit) begin
            @(negedge clk_i);
            guard++;
        end
        check("rst_mid.reach", 64'(guard < c_limit), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid.outputs", 64'({delay_o, load_o, bitslip_o, busy_o, done_o, fail_o, eye_o, slips_o}), 64'd0);
        rst_i = 1'b0;
        lp = load_pulses; bp = bs_pulses;
        repeat (100) @(negedge clk_i);
        check("rst_mid.loads", 64'(load_pulses - lp), 64'd0);
        check("rst_mid.slips", 64'(bs_pulses - bp), 64'd0);
        check("rst_mid.busy", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glitc_align_ctrl.md
Name: glitc_align_ctrl

Overview:
- Per-channel training controller for the GLITC input data path (IDELAY + ISERDES 1:4 P-side).
- On start, sweeps all 32 IDELAY taps and checks the deserialized word against a fixed training pattern at each tap. It then picks the centre of the longest passing window and loads that tap.
- Issues ISERDES bitslips and rescans if no adequate window is found.
- Drives the delay/load/bitslip controls in the clk_i domain. The serdes word is resynchronized to clk_i upstream.

Parameters:
- PATTERN, 4'b1010, expected 4-bit serdes word when aligned.
- SETTLE_CYCLES, 16, clk_i cycles to wait after a delay load before sampling (1..255).
- NSAMPLES, 64, consecutive matching samples required for a tap to pass (1..255).
- MIN_EYE, 4, minimum passing-run length (taps) accepted (1..32).
- MAX_SLIPS, 4, bitslips attempted before declaring failure (1..7).
- SLIP_WAIT, 32, clk_i cycles to wait after a bitslip pulse (1..255).

Ports:
- clk_i  in  1  control clock; all logic synchronous to it.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle request to run alignment; ignored while busy_o=1.
- serdes_i  in  4  serdes word, already synchronous to clk_i.
- delay_o  out  5  IDELAY tap value (to delay_clk_i).
- load_o  out  1  one-cycle load strobe (to load_clk_i).
- bitslip_o  out  1  one-cycle bitslip strobe (to bitslip_clk_i).
- busy_o  out  1  high from start acceptance until DONE/FAIL.
- done_o  out  1  sticky; alignment succeeded.
- fail_o  out  1  sticky; alignment failed.
- eye_o  out  32  pass map of the last scan; bit n = tap n passed.
- slips_o  out  3  bitslips issued in the current/last run.

Behaviour:
- Reset: state IDLE. delay_o=0, load_o=0, bitslip_o=0, busy_o=0, done_o=0, fail_o=0, eye_o=0, slips_o=0.
- Reset mid-operation aborts immediately to the reset values above. No further load or bitslip is issued.
- IDLE:
  - On start_i: busy_o=1, done_o=0, fail_o=0, slips_o=0, tap=0, eye_o=0 → LOAD.
  - start_i is also accepted in DONE or FAIL, with the same effect.
- LOAD: one cycle. delay_o=tap, load_o=1 → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: count NSAMPLES cycles.
  - Any cycle with serdes_i≠PATTERN marks the tap failed. No early exit; duration is fixed.
  - At the end, eye_o[tap] = pass → NEXT.
- NEXT: if tap=31 → ANALYZE, else tap+1 → LOAD. Per-tap time = 1+SETTLE_CYCLES+NSAMPLES+1 cycles.
- ANALYZE: one tap per cycle, 32 cycles, non-wrapping.
  - Track the current run start and length, and the best run start and length.
  - Update the best run only when strictly longer; on ties the earlier run wins.
  - Then:
    - If best_len ≥ MIN_EYE: centre = best_start + ((best_len−1)>>1) → APPLY.
    - Else if slips_o < MAX_SLIPS → SLIP.
    - Else → FAIL.
- SLIP: one cycle. bitslip_o=1, slips_o+1, eye_o cleared, tap=0 → SLIP_WAIT.
- SLIP_WAIT: SLIP_WAIT cycles → LOAD (full rescan).
- APPLY: one cycle. delay_o=centre, load_o=1 → DONE.
- DONE: busy_o=0, done_o=1. delay_o holds centre; eye_o holds the final map.
- FAIL: busy_o=0, fail_o=1. Issue a final load of tap 0 (one-cycle load_o with delay_o=0) on entry, then hold.
- load_o and bitslip_o are never asserted in the same cycle. Each is asserted only in its own state.
- Widths: tap and run counters are 6 bits internally, so a length of 32 is representable. Centre is truncated to 5 bits and always ≤31.

Test Plan:
- serdes_i constantly PATTERN, start → eye_o=32'hFFFFFFFF, slips_o=0, final load delay_o=15, done_o=1. Total busy time = 32×(SETTLE_CYCLES+NSAMPLES+2)+32+1 cycles.
- serdes_i matches only while delay_o∈[8,20] → eye_o=32'h001FFF00, delay_o=14, done_o=1.
- Matches for taps 2..5 and 10..20 → best window 10..20, delay_o=15. Equal windows 2..6 and 20..24 → delay_o=4 (earlier wins).
- Never matches → 4 bitslip pulses, each followed by a full rescan. slips_o=4, fail_o=1, done_o=0, final delay_o=0.
- Matches only after the first bitslip (taps 0..31) → slips_o=1, delay_o=15, done_o=1.
- rst_i asserted during SAMPLE at tap 7 → next cycle all outputs at reset values, no load/bitslip afterwards. start_i during busy ignored; a single injected mismatch within NSAMPLES clears exactly that tap's eye bit.
